// File: rtl/exu_alu_mdv.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit that borrows the shared EXU adder.
// One bit per iteration; XLEN iterations per operation, plus one NEG cycle for divide.
module exu_alu_mdv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mdv_i_valid,
  output logic            mdv_i_ready,
  input  logic [1:0]      mdv_i_op,
  input  logic [XLEN-1:0] mdv_i_rs1,
  input  logic [XLEN-1:0] mdv_i_rs2,
  output logic            mdv_o_valid,
  input  logic            mdv_o_ready,
  output logic [XLEN-1:0] mdv_o_wbck_wdat,
  output logic            mdv_busy,
  input  logic            mdv_flush,
  output logic            mdv_req_alu,
  output logic            mdv_req_alu_add,
  output logic [XLEN-1:0] mdv_req_alu_op1,
  output logic [XLEN-1:0] mdv_req_alu_op2,
  input  logic [XLEN-1:0] mdv_req_alu_add_res
);

  typedef enum logic [1:0] {StIdle, StNeg, StIter, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc holds hi (multiply) or rem (divide); sft holds lo or quo; opnd holds mcand or dvs.
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  sft_q, sft_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  ndvs_q, ndvs_d;

  logic             is_div;
  logic [XLEN:0]    sh;
  logic             ge;
  logic             carry;

  assign is_div = op_q[1];
  assign sh     = {acc_q, sft_q[XLEN-1]};
  assign ge     = sh[XLEN] | (sh[XLEN-1:0] >= opnd_q);
  assign carry  = mdv_req_alu_add_res < acc_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sft_d   = sft_q;
    opnd_d  = opnd_q;
    ndvs_d  = ndvs_q;
    unique case (state_q)
      StIdle: begin
        if (mdv_i_valid) begin
          op_d   = mdv_i_op;
          cnt_d  = '0;
          opnd_d = mdv_i_rs2;
          if (!mdv_i_op[1]) begin
            acc_d   = '0;
            sft_d   = mdv_i_rs1;
            state_d = StIter;
          end else if (mdv_i_rs2 != '0) begin
            acc_d   = '0;
            sft_d   = mdv_i_rs1;
            state_d = StNeg;
          end else begin
            acc_d   = mdv_i_rs1;
            sft_d   = '1;
            state_d = StDone;
          end
        end
      end
      StNeg: begin
        ndvs_d  = mdv_req_alu_add_res;
        state_d = StIter;
      end
      StIter: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div) begin
          acc_d = ge ? mdv_req_alu_add_res : sh[XLEN-1:0];
          sft_d = {sft_q[XLEN-2:0], ge};
        end else begin
          {acc_d, sft_d} = {carry, mdv_req_alu_add_res, sft_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = StDone;
      end
      StDone: begin
        if (mdv_o_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (mdv_flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sft_q   <= '0;
      opnd_q  <= '0;
      ndvs_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sft_q   <= sft_d;
      opnd_q  <= opnd_d;
      ndvs_q  <= ndvs_d;
    end
  end

  always_comb begin
    mdv_i_ready     = (state_q == StIdle);
    mdv_o_valid     = (state_q == StDone);
    mdv_busy        = (state_q != StIdle);
    mdv_req_alu     = 1'b0;
    mdv_req_alu_op1 = '0;
    mdv_req_alu_op2 = '0;
    mdv_o_wbck_wdat = '0;
    unique case (state_q)
      StNeg: begin
        mdv_req_alu     = 1'b1;
        mdv_req_alu_op1 = ~opnd_q;
        mdv_req_alu_op2 = XLEN'(1);
      end
      StIter: begin
        mdv_req_alu = 1'b1;
        if (is_div) begin
          mdv_req_alu_op1 = sh[XLEN-1:0];
          mdv_req_alu_op2 = ndvs_q;
        end else begin
          mdv_req_alu_op1 = acc_q;
          mdv_req_alu_op2 = sft_q[0] ? opnd_q : '0;
        end
      end
      // op[0] selects the high/remainder half for MULHU and REMU.
      StDone:  mdv_o_wbck_wdat = op_q[0] ? acc_q : sft_q;
      default: ;
    endcase
    mdv_req_alu_add = mdv_req_alu;
  end

endmodule

// File: tb/tb_exu_alu_mdv.sv
// Bench for exu_alu_mdv: directed and random operations checked against plain
// arithmetic, with latency, request-cycle, stall, flush and async reset checks.
module tb_exu_alu_mdv;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready;
  logic [1:0]      i_op = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            o_valid;
  logic            o_ready = 1'b0;
  logic [XLEN-1:0] wdat;
  logic            busy;
  logic            flush = 1'b0;
  logic            req_alu;
  logic            req_add;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] add_res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign add_res = op1 + op2;

  exu_alu_mdv #(.XLEN(XLEN), .CNT_W(6)) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mdv_i_valid         (i_valid),
    .mdv_i_ready         (i_ready),
    .mdv_i_op            (i_op),
    .mdv_i_rs1           (rs1),
    .mdv_i_rs2           (rs2),
    .mdv_o_valid         (o_valid),
    .mdv_o_ready         (o_ready),
    .mdv_o_wbck_wdat     (wdat),
    .mdv_busy            (busy),
    .mdv_flush           (flush),
    .mdv_req_alu         (req_alu),
    .mdv_req_alu_add     (req_add),
    .mdv_req_alu_op1     (op1),
    .mdv_req_alu_op2     (op2),
    .mdv_req_alu_add_res (add_res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    logic [31:0] exp_res;
    int exp_lat, exp_req, lat, reqc;
    exp_res = model(op, a, b);
    if (!op[1]) begin
      exp_lat = XLEN + 1; exp_req = XLEN;
    end else if (b == 0) begin
      exp_lat = 1; exp_req = 0;
    end else begin
      exp_lat = XLEN + 2; exp_req = XLEN + 1;
    end
    check("i_ready_idle", 32'(i_ready), 32'd1);
    i_valid = 1'b1; i_op = op; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1; reqc = 0;
    while (!o_valid && lat < 100) begin
      reqc += int'(req_alu);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("req_cycles", 32'(reqc), 32'(exp_req));
    check("wdat", wdat, exp_res);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_wdat", wdat, exp_res);
      check("hold_irdy", 32'(i_ready), 32'd0);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    check("irdy_after", 32'(i_ready), 32'd1);
    check("ovalid_after", 32'(o_valid), 32'd0);
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    #2;
    check("rst_irdy", 32'(i_ready), 32'd1);
    check("rst_ovalid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(req_alu), 32'd0);
    check("rst_wdat", wdat, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd0, 32'd7, 32'd6, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'd100, 32'd7, 0);
    run_op(2'd3, 32'd100, 32'd7, 0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(2'd2, 32'd5, 32'd0, 0);
    run_op(2'd3, 32'd5, 32'd0, 0);
    run_op(2'd0, 32'd12345, 32'd678, 5);
    run_op(2'd2, 32'd1000, 32'd3, 0);

    // Flush mid-iteration: no result may ever appear.
    i_valid = 1'b1; i_op = 2'd0; rs1 = 32'd11; rs2 = 32'd13;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_irdy", 32'(i_ready), 32'd1);
    check("flush_req", 32'(req_alu), 32'd0);
    seen = 0;
    repeat (40) begin
      seen |= int'(o_valid);
      @(posedge clk); #1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Async reset mid-iteration, asserted away from the clock edge.
    i_valid = 1'b1; i_op = 2'd0; rs1 = 32'd1234; rs2 = 32'd5678;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_irdy", 32'(i_ready), 32'd1);
    check("arst_ovalid", 32'(o_valid), 32'd0);
    check("arst_req", 32'(req_alu), 32'd0);
    check("arst_op1", op1, 32'd0);
    check("arst_op2", op2, 32'd0);
    check("arst_wdat", wdat, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'd0, 32'd3, 32'd3, 0);

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
